// File: rtl/bsync_multi.sv
`default_nettype none
// bsync_multi: NUM_CH skewed sync pulse outputs framed by a free-running period, mode chosen by a debounced key.
// Optional long-press handling (hold forces OFF, mode advances on release) is enabled by defining BSYNC_LONG_PRESS_EN.
module bsync_multi #(
  parameter int NUM_CH         = 4,
  parameter int PERIOD_CYC     = 1000,
  parameter int PULSE_CYC      = 10,
  parameter int SKEW_CYC       = 50,
  parameter int BURST_LEN      = 8,
  parameter int DEBOUNCE_CYC   = 1000,
  parameter int LONG_PRESS_CYC = 100000
) (
  input  logic              IO_SYS_CLK,
  input  logic              IO_RESET_KEY,
  input  logic              IO_MODE_KEY,
  output logic [NUM_CH-1:0] IO_BSYNC_OUT,
  output logic              LED1,
  output logic              LED2,
  output logic              FRAME_START
);

  localparam int c_CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int c_DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int c_BST_W = $clog2(BURST_LEN + 1);

  localparam logic [1:0] c_MODE_OFF   = 2'd0;
  localparam logic [1:0] c_MODE_CONT  = 2'd1;
  localparam logic [1:0] c_MODE_BURST = 2'd2;
  localparam logic [1:0] c_MODE_HALF  = 2'd3;

  if (NUM_CH < 1 || NUM_CH > 8 || PULSE_CYC < 1 || BURST_LEN < 1 || DEBOUNCE_CYC < 1 ||
      LONG_PRESS_CYC < 1 || (NUM_CH - 1) * SKEW_CYC + PULSE_CYC > PERIOD_CYC) begin : g_cfg_check
    $error("bsync_multi: illegal parameter combination");
  end

  logic               sync1_q, sync2_q;
  logic               deb_q, deb_d, deb_prev_q;
  logic [c_DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic               par_q, par_d;
  logic [c_BST_W-1:0] burst_q, burst_d;
  logic [NUM_CH-1:0]  out_q, out_d, w_win;
  logic               w_chg, w_wrap, w_en;
  logic [31:0]        w_cnt_ext;

  // Debounced level only follows the synchronized key after DEBOUNCE_CYC consecutive differing cycles.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == c_DEB_W'(DEBOUNCE_CYC - 1)) deb_d = sync2_q;
      else                                          deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

`ifdef BSYNC_LONG_PRESS_EN
  localparam int c_HOLD_W = $clog2(LONG_PRESS_CYC + 1);

  logic                lp_q, lp_d;
  logic [c_HOLD_W-1:0] hold_q, hold_d;
  logic                w_release, w_long;

  assign w_release = deb_q & ~deb_prev_q;
  assign w_long    = ~deb_q & ~lp_q & (hold_q == c_HOLD_W'(LONG_PRESS_CYC - 1));

  always_comb begin
    hold_d = hold_q;
    lp_d   = lp_q;
    if (deb_q)      hold_d = '0;
    else if (!lp_q) hold_d = hold_q + 1'b1;
    if (w_long)         lp_d = 1'b1;
    else if (w_release) lp_d = 1'b0;
  end

  always_ff @(posedge IO_SYS_CLK) begin
    if (IO_RESET_KEY) begin
      hold_q <= '0;
      lp_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      lp_q   <= lp_d;
    end
  end

  // A release that ends a long press has already been consumed by the forced OFF.
  always_comb begin
    mode_d = mode_q;
    if (w_long)                  mode_d = c_MODE_OFF;
    else if (w_release && !lp_q) mode_d = mode_q + 2'd1;
  end
`else
  logic w_press;

  assign w_press = deb_prev_q & ~deb_q;

  always_comb begin
    mode_d = mode_q;
    if (w_press) mode_d = mode_q + 2'd1;
  end
`endif

  always_ff @(posedge IO_SYS_CLK) begin
    if (IO_RESET_KEY) mode_q <= c_MODE_OFF;
    else              mode_q <= mode_d;
  end

  always_comb begin
    LED1        = mode_q[0];
    LED2        = mode_q[1];
    FRAME_START = (mode_q != c_MODE_OFF) && (cnt_q == '0);
  end

  assign w_chg     = (mode_d != mode_q);
  assign w_wrap    = (mode_q != c_MODE_OFF) && (cnt_q == c_CNT_W'(PERIOD_CYC - 1));
  assign w_cnt_ext = 32'(cnt_q);

  always_comb begin
    case (mode_q)
      c_MODE_CONT:  w_en = 1'b1;
      c_MODE_BURST: w_en = (burst_q != c_BST_W'(BURST_LEN));
      c_MODE_HALF:  w_en = ~par_q;
      default:      w_en = 1'b0;
    endcase
  end

  // Unsigned wrap makes counts below the window start fall outside the pulse width.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign w_win[k] = (w_cnt_ext - 32'(k * SKEW_CYC)) < 32'(PULSE_CYC);
  end

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    par_d   = par_q;
    burst_d = burst_q;
    out_d   = w_en ? w_win : '0;
    if (w_chg) begin
      cnt_d   = '0;
      par_d   = 1'b0;
      burst_d = '0;
      out_d   = '0;
    end else if (mode_q == c_MODE_OFF) begin
      cnt_d = '0;
    end else if (w_wrap) begin
      cnt_d = '0;
      par_d = ~par_q;
      if (burst_q != c_BST_W'(BURST_LEN)) burst_d = burst_q + 1'b1;
    end
  end

  always_ff @(posedge IO_SYS_CLK) begin
    if (IO_RESET_KEY) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      deb_q      <= 1'b1;
      deb_prev_q <= 1'b1;
      deb_cnt_q  <= '0;
      cnt_q      <= '0;
      par_q      <= 1'b0;
      burst_q    <= '0;
      out_q      <= '0;
    end else begin
      sync1_q    <= IO_MODE_KEY;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
      cnt_q      <= cnt_d;
      par_q      <= par_d;
      burst_q    <= burst_d;
      out_q      <= out_d;
    end
  end

  assign IO_BSYNC_OUT = out_q;

endmodule
`default_nettype wire

// File: tb/tb_bsync_multi.sv
`default_nettype none
// tb_bsync_multi: frame/phase-level reference model checked every cycle, plus directed literal checks.
module tb_bsync_multi;
  localparam int NCH = 3, PER = 20, PUL = 2, SKW = 5, BL = 2, DEB = 4, LP = 30;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           key = 1'b1;
  logic [NCH-1:0] bs;
  logic           led1, led2, fs;

  int n_checks = 0;
  int n_fail   = 0;

  bsync_multi #(
    .NUM_CH(NCH), .PERIOD_CYC(PER), .PULSE_CYC(PUL), .SKEW_CYC(SKW),
    .BURST_LEN(BL), .DEBOUNCE_CYC(DEB), .LONG_PRESS_CYC(LP)
  ) dut (
    .IO_SYS_CLK(clk), .IO_RESET_KEY(rst), .IO_MODE_KEY(key),
    .IO_BSYNC_OUT(bs), .LED1(led1), .LED2(led2), .FRAME_START(fs)
  );

  always #5 clk = ~clk;

  // Model: key path as sync stages + run length; frames as elapsed cycles since the mode was entered.
  int             m_s1, m_s2, m_deb, m_prevdeb, m_run, m_mode, m_phase, m_low, m_lp;
  logic [NCH-1:0] m_out;

  function automatic bit frame_en(input int mode, input int frame);
    case (mode)
      1:       return 1'b1;
      2:       return frame < BL;
      3:       return (frame % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic k);
    int n_s1, n_s2, n_deb, n_run, n_mode, n_phase, n_low, n_lp, cnt, frame;
    logic [NCH-1:0] n_out;
    if (r) begin
      m_s1 = 1; m_s2 = 1; m_deb = 1; m_prevdeb = 1; m_run = 0;
      m_mode = 0; m_phase = 0; m_low = 0; m_lp = 0; m_out = '0;
      return;
    end
    n_s1 = k; n_s2 = m_s1; n_deb = m_deb; n_run = 0;
    if (m_s2 != m_deb) begin
      if (m_run + 1 == DEB) n_deb = m_s2;
      else                  n_run = m_run + 1;
    end
    n_mode = m_mode; n_lp = m_lp;
`ifdef BSYNC_LONG_PRESS_EN
    if (m_deb == 0 && m_low == LP && m_lp == 0) begin
      n_mode = 0; n_lp = 1;
    end else if (m_deb == 1 && m_prevdeb == 0) begin
      if (m_lp == 0) n_mode = (m_mode + 1) % 4;
      n_lp = 0;
    end
`else
    if (m_prevdeb == 1 && m_deb == 0) n_mode = (m_mode + 1) % 4;
`endif
    n_low = (n_deb == 0) ? m_low + 1 : 0;
    cnt   = m_phase % PER;
    frame = m_phase / PER;
    for (int c = 0; c < NCH; c++)
      n_out[c] = (n_mode == m_mode) && frame_en(m_mode, frame) && cnt >= c * SKW && cnt < c * SKW + PUL;
    n_phase = (n_mode != m_mode || m_mode == 0) ? 0 : m_phase + 1;
    m_prevdeb = m_deb;
    m_s1 = n_s1; m_s2 = n_s2; m_deb = n_deb; m_run = n_run; m_mode = n_mode;
    m_lp = n_lp; m_low = n_low; m_out = n_out; m_phase = n_phase;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(rst, key);
      #1;
      check("model_bsync_out", int'(bs), int'(m_out));
      check("model_mode_leds", int'({led2, led1}), m_mode);
      check("model_frame_start", int'(fs), int'(m_mode != 0 && (m_phase % PER) == 0));
    end
  end

  // Drives an active-low press of up to 10 cycles and waits (bounded) for the target mode.
  task automatic press_to(input int want, input string name, output int lat);
    lat = -1;
    key = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (i == 9) key = 1'b1;
      if (int'({led2, led1}) == want) begin
        lat = i;
        break;
      end
    end
    key = 1'b1;
    check(name, int'({led2, led1}), want);
  endtask

  task automatic window(input int n, output int nfs, output int c0, output int c1, output int c2);
    nfs = 0; c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      nfs += int'(fs); c0 += int'(bs[0]); c1 += int'(bs[1]); c2 += int'(bs[2]);
    end
  endtask

  int lat, nfs, c0, c1, c2;
`ifdef BSYNC_LONG_PRESS_EN
  localparam int PRESS_LAT = 16;
`else
  localparam int PRESS_LAT = 6;
`endif

  initial begin
    rst = 1'b1; key = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_bsync", int'(bs), 0);
    check("reset_leds", int'({led2, led1}), 0);
    check("reset_fs", int'(fs), 0);
    rst = 1'b0;

    key = 1'b0; repeat (3) @(negedge clk); key = 1'b1;
    repeat (15) @(negedge clk);
    check("short_glitch_ignored", int'({led2, led1}), 0);

    press_to(1, "enter_cont", lat);
    check("press_latency", lat, PRESS_LAT);
    window(60, nfs, c0, c1, c2);
    check("cont_frame_starts", nfs, 3);
    check("cont_ch0_cycles", c0, 6);
    check("cont_ch1_cycles", c1, 6);
    check("cont_ch2_cycles", c2, 6);

    press_to(2, "enter_burst", lat);
    window(100, nfs, c0, c1, c2);
    check("burst_frame_starts", nfs, 5);
    check("burst_ch0_cycles", c0, 4);
    check("burst_ch2_cycles", c2, 4);

    press_to(3, "enter_half", lat);
    window(100, nfs, c0, c1, c2);
    check("half_frame_starts", nfs, 5);
    check("half_ch0_cycles", c0, 6);
    check("half_ch1_cycles", c1, 6);

    press_to(0, "half_to_off", lat);
    check("off_bsync_cut", int'(bs), 0);
    check("off_fs", int'(fs), 0);
    repeat (15) @(negedge clk);
    press_to(1, "off_to_cont", lat);
    repeat (15) @(negedge clk);
    press_to(2, "reenter_burst", lat);
    window(100, nfs, c0, c1, c2);
    check("burst_rearm_ch0_cycles", c0, 4);

    press_to(3, "reenter_half", lat);
    repeat (33) @(negedge clk);
    press_to(0, "half_frame1_cnt19_to_off", lat);
    check("aligned_press_latency", lat, PRESS_LAT);
    check("aligned_off_bsync", int'(bs), 0);
    check("aligned_off_fs", int'(fs), 0);

`ifdef BSYNC_LONG_PRESS_EN
    repeat (15) @(negedge clk);
    press_to(1, "lp_enter_cont", lat);
    repeat (15) @(negedge clk);
    key = 1'b0;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (int'({led2, led1}) == 0) begin
        lat = i;
        break;
      end
    end
    check("long_press_latency", lat, 35);
    check("long_press_bsync", int'(bs), 0);
    repeat (4) @(negedge clk);
    key = 1'b1;
    repeat (30) @(negedge clk);
    check("long_press_release_ignored", int'({led2, led1}), 0);
`endif

    repeat (5) @(negedge clk);
    press_to(1, "pre_reset_cont", lat);
    repeat (25) @(negedge clk);
    key = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    key = 1'b1;
    @(negedge clk);
    check("midrun_reset_bsync", int'(bs), 0);
    check("midrun_reset_leds", int'({led2, led1}), 0);
    check("midrun_reset_fs", int'(fs), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("no_action_after_reset", int'({led2, led1}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
